// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1-BR control sequencer: opcodes, ULA selects, T-states.
// Latency: n/a (constants, types and pure combinational helpers only).
// Backpressure: n/a.
package sap_pkg;

    // Instruction opcodes (upper nibble of IR)
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // ULA select {XOR_NOT, ADD_SUB, ALU1_OR, ALU0_AND}
    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_SUB = 4'b0100;
    localparam logic [3:0] SEL_AND = 4'b0001;
    localparam logic [3:0] SEL_OR  = 4'b0010;
    localparam logic [3:0] SEL_XOR = 4'b0011;
    localparam logic [3:0] SEL_NOT = 4'b1011;

    // One-hot T-states, bit0 = T1
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Run/halt state of the sequencer
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_e;

    // Full control word issued every cycle
    typedef struct packed {
        logic       pc_out;
        logic       pc_inc;
        logic       mar_in;
        logic       ram_out;
        logic       ir_in;
        logic       ir_out;
        logic       a_in;
        logic       a_out;
        logic       b_in;
        logic       out_in;
        logic       alu_out;
        logic [3:0] alu_sel;
        logic       hlt;
    } ctrl_t;

    // Two-operand ULA instructions share the same fetch-operand sequence
    function automatic logic is_alu2_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic logic [3:0] alu_sel_of(input logic [3:0] op);
        logic [3:0] sel;
        sel = SEL_ADD;
        case (op)
            OP_SUB:  sel = SEL_SUB;
            OP_AND:  sel = SEL_AND;
            OP_OR:   sel = SEL_OR;
            OP_XOR:  sel = SEL_XOR;
            OP_NOT:  sel = SEL_NOT;
            default: sel = SEL_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/controle_sequenciador_if.sv
// Control interface between the sequencer (master) and the SAP-1-BR datapath/ULA (slave).
// Latency: n/a (wires only). Backpressure: none, strobes are issued every cycle.
// Ports: OPCODE into the sequencer; T_STATE, bus/load strobes, ULA selects and HLT out of it.
interface controle_sequenciador_if #(
    parameter int OP_W = 4,
    parameter int N_T  = 6
);
    logic [OP_W-1:0] OPCODE;
    logic [N_T-1:0]  T_STATE;
    logic PC_OUT, PC_INC, MAR_IN, RAM_OUT, IR_IN, IR_OUT;
    logic A_IN, A_OUT, B_IN, OUT_IN, ALU_OUT;
    logic XOR_NOT, ADD_SUB, ALU1_OR, ALU0_AND;
    logic HLT;

    modport master (
        input  OPCODE,
        output T_STATE, PC_OUT, PC_INC, MAR_IN, RAM_OUT, IR_IN, IR_OUT,
               A_IN, A_OUT, B_IN, OUT_IN, ALU_OUT,
               XOR_NOT, ADD_SUB, ALU1_OR, ALU0_AND, HLT
    );

    modport slave (
        output OPCODE,
        input  T_STATE, PC_OUT, PC_INC, MAR_IN, RAM_OUT, IR_IN, IR_OUT,
               A_IN, A_OUT, B_IN, OUT_IN, ALU_OUT,
               XOR_NOT, ADD_SUB, ALU1_OR, ALU0_AND, HLT
    );
endinterface

// File: rtl/controle_sequenciador_anel_t.sv
// One-hot T-state ring counter (T1..T6) with synchronous reset, hold and illegal-state recovery.
// Latency: state changes on the rising edge; output is the registered ring.
// Backpressure: hold=1 freezes the ring; a non-one-hot value returns to T1 even while held.
// Ports: clk, rst (sync, active-high), hold, ring (one-hot, bit0 = T1).
module anel_t #(
    parameter int N_T = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hold,
    output logic [N_T-1:0] ring
);
    localparam logic [N_T-1:0] RING_T1 = {{(N_T-1){1'b0}}, 1'b1};

    logic [N_T-1:0] ring_q;
    logic [N_T-1:0] ring_d;

    always_comb begin
        ring_d = ring_q;
        if (!$onehot(ring_q)) begin
            ring_d = RING_T1;
        end else if (!hold) begin
            ring_d = {ring_q[N_T-2:0], ring_q[N_T-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q <= RING_T1;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring = ring_q;

endmodule

// File: rtl/controle_sequenciador.sv
// SAP-1-BR control sequencer: decodes (T-state, OPCODE, halted) into the datapath control word.
// Latency: control word is combinational, valid in the same cycle as its T-state.
// Backpressure: none; HLT freezes the ring at T4 until CLR, CLR forces all strobes to 0.
// Ports: CLK, CLR (sync, active-high), bus (master side: OPCODE in, T_STATE/strobes/selects/HLT out).
module controle_sequenciador
    import sap_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int N_T  = 6
) (
    input  logic                    CLK,
    input  logic                    CLR,
    controle_sequenciador_if.master bus
);
    logic [OP_W-1:0] opcode;
    logic [N_T-1:0]  t_state;
    run_e            run_q;
    run_e            run_d;
    ctrl_t           ctrl;

    assign opcode = bus.OPCODE;

    // Ring keeps its current value on the halting edge itself, so it parks at T4
    anel_t #(.N_T(N_T)) u_anel (
        .clk  (CLK),
        .rst  (CLR),
        .hold (run_d == ST_HALT),
        .ring (t_state)
    );

    always_comb begin
        run_d = run_q;
        if (run_q == ST_RUN && t_state == T4 && opcode == OP_HLT) begin
            run_d = ST_HALT;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            run_q <= ST_RUN;
        end else begin
            run_q <= run_d;
        end
    end

    always_comb begin
        ctrl = '0;
        if (CLR) begin
            ctrl = '0;
        end else if (run_q == ST_HALT) begin
            ctrl.hlt = 1'b1;
        end else begin
            case (t_state)
                T1: begin
                    ctrl.pc_out = 1'b1;
                    ctrl.mar_in = 1'b1;
                end
                T2: ctrl.pc_inc = 1'b1;
                T3: begin
                    ctrl.ram_out = 1'b1;
                    ctrl.ir_in   = 1'b1;
                end
                T4: begin
                    if (opcode == OP_LDA || is_alu2_op(opcode)) begin
                        ctrl.ir_out = 1'b1;
                        ctrl.mar_in = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        ctrl.a_out  = 1'b1;
                        ctrl.out_in = 1'b1;
                    end else if (opcode == OP_HLT) begin
                        ctrl.hlt = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ctrl.ram_out = 1'b1;
                        ctrl.a_in    = 1'b1;
                    end else if (is_alu2_op(opcode)) begin
                        ctrl.ram_out = 1'b1;
                        ctrl.b_in    = 1'b1;
                    end
                end
                T6: begin
                    if (is_alu2_op(opcode) || opcode == OP_NOT) begin
                        ctrl.alu_out = 1'b1;
                        ctrl.a_in    = 1'b1;
                        ctrl.alu_sel = alu_sel_of(opcode);
                    end
                end
                // Illegal ring values issue nothing; the ring recovers next edge
                default: ctrl = '0;
            endcase
        end
    end

    assign bus.T_STATE  = t_state;
    assign bus.PC_OUT   = ctrl.pc_out;
    assign bus.PC_INC   = ctrl.pc_inc;
    assign bus.MAR_IN   = ctrl.mar_in;
    assign bus.RAM_OUT  = ctrl.ram_out;
    assign bus.IR_IN    = ctrl.ir_in;
    assign bus.IR_OUT   = ctrl.ir_out;
    assign bus.A_IN     = ctrl.a_in;
    assign bus.A_OUT    = ctrl.a_out;
    assign bus.B_IN     = ctrl.b_in;
    assign bus.OUT_IN   = ctrl.out_in;
    assign bus.ALU_OUT  = ctrl.alu_out;
    assign bus.XOR_NOT  = ctrl.alu_sel[3];
    assign bus.ADD_SUB  = ctrl.alu_sel[2];
    assign bus.ALU1_OR  = ctrl.alu_sel[1];
    assign bus.ALU0_AND = ctrl.alu_sel[0];
    assign bus.HLT      = ctrl.hlt;

endmodule
